// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - shared opcodes, state encoding and control word for the uc_seq sequencer
package uc_pkg;

    localparam int CNT_W_DEF = 16;

    // Full 6-bit opcodes (instruction bits [15:10])
    localparam logic [5:0] OPC_NOP  = 6'b000000;
    localparam logic [5:0] OPC_J    = 6'b000001;
    localparam logic [5:0] OPC_JZ   = 6'b000010;
    localparam logic [5:0] OPC_JNZ  = 6'b000011;
    localparam logic [5:0] OPC_HALT = 6'b000111;

    // Prefix classes: ALU is 1ooo_xx, LI is 01xx_xx
    localparam logic       OPC_ALU_PFX = 1'b1;
    localparam logic [1:0] OPC_LI_PFX  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0] op;
        logic       s_inc;
        logic       s_abs;
        logic       s_inm;
        logic       we3;
        logic       wez;
    } ctrl_t;

    // Control word driven whenever nothing is being executed: PC would
    // increment if enabled, but no enable is ever raised with this word.
    localparam ctrl_t CTRL_DEFAULT = '{
        op:    3'b000,
        s_inc: 1'b1,
        s_abs: 1'b0,
        s_inm: 1'b0,
        we3:   1'b0,
        wez:   1'b0
    };

endpackage

// File: rtl/uc_deco.sv
// rtl/uc_deco.sv - combinational instruction decoder for uc_seq
//   ir      in   6  latched opcode
//   zq      in   1  zero flag latched together with ir
//   ctrl    out     datapath control word (op, selects, write enables)
//   illegal out  1  opcode is not part of the instruction set
//   is_halt out  1  opcode is HALT
module uc_deco
    import uc_pkg::*;
(
    input  logic [5:0] ir,
    input  logic       zq,
    output ctrl_t      ctrl,
    output logic       illegal,
    output logic       is_halt
);

    always_comb begin
        ctrl    = CTRL_DEFAULT;
        illegal = 1'b0;
        is_halt = 1'b0;

        if (ir[5] == OPC_ALU_PFX) begin
            ctrl.op  = ir[4:2];
            ctrl.we3 = 1'b1;
            ctrl.wez = 1'b1;
        end else if (ir[5:4] == OPC_LI_PFX) begin
            ctrl.s_inm = 1'b1;
            ctrl.we3   = 1'b1;
        end else begin
            case (ir)
                OPC_NOP: begin
                end
                // A taken jump loads the absolute target, so the
                // increment select is dropped whenever s_abs is raised.
                OPC_J: begin
                    ctrl.s_abs = 1'b1;
                    ctrl.s_inc = 1'b0;
                end
                OPC_JZ: begin
                    ctrl.s_abs = zq;
                    ctrl.s_inc = ~zq;
                end
                OPC_JNZ: begin
                    ctrl.s_abs = ~zq;
                    ctrl.s_inc = zq;
                end
                OPC_HALT: begin
                    is_halt = 1'b1;
                end
                default: begin
                    illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uc_seq.sv
// rtl/uc_seq.sv - fetch/execute sequencer with run, single-step and halt control
//   clk, reset          clock and asynchronous active-low reset
//   run                 level, execute continuously
//   step_req, resume    one-cycle pulses: single step while stopped, leave HALTED
//   opcode, z           program memory opcode bits and datapath zero flag
//   s_inc..wez, op      datapath control word (only live in EXEC)
//   pc_en               PC load enable, one pulse per executed instruction
//   busy, halted        FSM status
//   step_ack            one-cycle pulse after a single-stepped instruction
//   illegal             sticky, set by an undefined opcode
//   retired             saturating count of executed instructions
module uc_seq
    import uc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step_req,
    input  logic             resume,
    input  logic [5:0]       opcode,
    input  logic             z,
    output logic             s_inc,
    output logic             s_abs,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       op,
    output logic             pc_en,
    output logic             busy,
    output logic             halted,
    output logic             step_ack,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q, state_d;
    logic [5:0]       ir_q, ir_d;
    logic             zq_q, zq_d;
    logic             step_mode_q, step_mode_d;
    logic             step_ack_q, step_ack_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    ctrl_t            deco_ctrl;
    logic             deco_illegal;
    logic             deco_halt;
    ctrl_t            ctrl_o;
    logic             pc_en_o;

    uc_deco u_deco (
        .ir      (ir_q),
        .zq      (zq_q),
        .ctrl    (deco_ctrl),
        .illegal (deco_illegal),
        .is_halt (deco_halt)
    );

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        zq_d        = zq_q;
        step_mode_d = step_mode_q;
        step_ack_d  = 1'b0;
        illegal_d   = illegal_q;
        retired_d   = retired_q;
        ctrl_o      = CTRL_DEFAULT;
        pc_en_o     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end else if (step_req) begin
                    state_d     = ST_FETCH;
                    step_mode_d = 1'b1;
                end
            end
            // Flag is captured with the opcode so a conditional jump sees
            // the zero flag as it was when the instruction was fetched.
            ST_FETCH: begin
                ir_d    = opcode;
                zq_d    = z;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                ctrl_o      = deco_ctrl;
                pc_en_o     = 1'b1;
                retired_d   = (retired_q == '1) ? retired_q : retired_q + CNT_W'(1);
                illegal_d   = illegal_q | deco_illegal;
                step_ack_d  = step_mode_q;
                step_mode_d = 1'b0;
                if (deco_halt) begin
                    state_d = ST_HALTED;
                end else if (step_mode_q) begin
                    state_d = ST_IDLE;
                end else if (run) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ir_q        <= '0;
            zq_q        <= 1'b0;
            step_mode_q <= 1'b0;
            step_ack_q  <= 1'b0;
            illegal_q   <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            zq_q        <= zq_d;
            step_mode_q <= step_mode_d;
            step_ack_q  <= step_ack_d;
            illegal_q   <= illegal_d;
            retired_q   <= retired_d;
        end
    end

    // Enables come straight from the state register, so an asynchronous
    // reset forces them low without waiting for a clock edge.
    assign op       = ctrl_o.op;
    assign s_inc    = ctrl_o.s_inc;
    assign s_abs    = ctrl_o.s_abs;
    assign s_inm    = ctrl_o.s_inm;
    assign we3      = ctrl_o.we3;
    assign wez      = ctrl_o.wez;
    assign pc_en    = pc_en_o;
    assign busy     = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    assign halted   = (state_q == ST_HALTED);
    assign step_ack = step_ack_q;
    assign illegal  = illegal_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_uc_seq.sv
// tb/tb_uc_seq.sv - self-checking bench for uc_seq
module tb_uc_seq;

    typedef struct packed {
        logic [2:0] op;
        logic       s_inc;
        logic       s_abs;
        logic       s_inm;
        logic       we3;
        logic       wez;
    } cw_t;

    localparam logic [5:0] I_NOP  = 6'b000000;
    localparam logic [5:0] I_J    = 6'b000001;
    localparam logic [5:0] I_JZ   = 6'b000010;
    localparam logic [5:0] I_JNZ  = 6'b000011;
    localparam logic [5:0] I_HALT = 6'b000111;
    localparam logic [5:0] I_ILL  = 6'b000100;
    localparam logic [5:0] I_LI   = 6'b010011;
    localparam logic [5:0] I_ALU2 = 6'b101000;
    localparam logic [5:0] I_ALU3 = 6'b101100;
    localparam logic [5:0] I_ALU7 = 6'b111110;

    logic        clk = 1'b0;
    logic        reset, run, step_req, resume, z;
    logic [5:0]  opcode;
    logic        s_inc, s_abs, s_inm, we3, wez, pc_en, busy, halted, step_ack, illegal;
    logic [2:0]  op;
    logic [15:0] retired;
    logic        b_s_inc, b_s_abs, b_s_inm, b_we3, b_wez, b_pc_en, b_busy, b_halted, b_step_ack, b_illegal;
    logic [2:0]  b_op;
    logic [3:0]  b_retired;

    cw_t        sb_q[$];
    logic [5:0] prog_q[$];
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    uc_seq dut (
        .clk(clk), .reset(reset), .run(run), .step_req(step_req), .resume(resume),
        .opcode(opcode), .z(z), .s_inc(s_inc), .s_abs(s_abs), .s_inm(s_inm),
        .we3(we3), .wez(wez), .op(op), .pc_en(pc_en), .busy(busy), .halted(halted),
        .step_ack(step_ack), .illegal(illegal), .retired(retired)
    );

    uc_seq #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .run(run), .step_req(step_req), .resume(resume),
        .opcode(opcode), .z(z), .s_inc(b_s_inc), .s_abs(b_s_abs), .s_inm(b_s_inm),
        .we3(b_we3), .wez(b_wez), .op(b_op), .pc_en(b_pc_en), .busy(b_busy), .halted(b_halted),
        .step_ack(b_step_ack), .illegal(b_illegal), .retired(b_retired)
    );

    // Expected control word for an opcode and the flag value latched with it
    function automatic cw_t exp_word(input logic [5:0] o, input logic zl);
        cw_t w;
        w = '{op: 3'b000, s_inc: 1'b1, s_abs: 1'b0, s_inm: 1'b0, we3: 1'b0, wez: 1'b0};
        if (o[5]) begin
            w.op = o[4:2]; w.we3 = 1'b1; w.wez = 1'b1;
        end else if (o[5:4] == 2'b01) begin
            w.s_inm = 1'b1; w.we3 = 1'b1;
        end else if (o == I_J) begin
            w.s_abs = 1'b1; w.s_inc = 1'b0;
        end else if (o == I_JZ) begin
            w.s_abs = zl; w.s_inc = ~zl;
        end else if (o == I_JNZ) begin
            w.s_abs = ~zl; w.s_inc = zl;
        end
        return w;
    endfunction

    // Advance to the next falling edge and consume the scoreboard on pc_en
    task automatic tick(output bit pe);
        cw_t a, e;
        @(negedge clk);
        pe = (pc_en === 1'b1);
        a  = {op, s_inc, s_abs, s_inm, we3, wez};
        vectors++;
        if (pe) begin
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pc_en: got pc_en=1 at %0t, required no pending instruction", $time);
            end else begin
                e = sb_q.pop_front();
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL ctrl_word: got op=%b inc=%b abs=%b inm=%b we3=%b wez=%b, required op=%b inc=%b abs=%b inm=%b we3=%b wez=%b",
                             a.op, a.s_inc, a.s_abs, a.s_inm, a.we3, a.wez,
                             e.op, e.s_inc, e.s_abs, e.s_inm, e.we3, e.wez);
                end
            end
        end else if ({we3, wez, pc_en} !== 3'b000) begin
            miscompares++;
            $display("FAIL enables_outside_exec: got we3/wez/pc_en=%b, required 000", {we3, wez, pc_en});
        end
    endtask

    task automatic apply_reset();
        bit pe;
        reset = 1'b0; run = 1'b0; step_req = 1'b0; resume = 1'b0;
        tick(pe);
        tick(pe);
        reset = 1'b1;
        tick(pe);
    endtask

    task automatic run_prog(output logic [31:0] we3_tr, output logic [31:0] wez_tr, output logic [31:0] pe_tr);
        int  budget;
        int  k;
        bit  pe;
        bit  done;
        we3_tr = '0; wez_tr = '0; pe_tr = '0;
        budget = 2 * prog_q.size() + 8;
        done   = 1'b0;
        k      = 0;
        opcode = prog_q[0];
        sb_q.push_back(exp_word(prog_q[0], z));
        run = 1'b1;
        while (!done && k < budget) begin
            k++;
            tick(pe);
            if (k < 32) begin
                we3_tr[k] = we3; wez_tr[k] = wez; pe_tr[k] = pe;
            end
            if (pe) begin
                prog_q.delete(0);
                if (prog_q.size() == 0) begin
                    run  = 1'b0;
                    done = 1'b1;
                end else begin
                    opcode = prog_q[0];
                    sb_q.push_back(exp_word(prog_q[0], z));
                end
            end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            run = 1'b0;
            $display("FAIL run_prog_timeout: got %0d instructions left, required 0", prog_q.size());
            prog_q.delete();
        end
        tick(pe);
    endtask

    task automatic exec_one(input logic [5:0] opc, input logic zv, input bit step, input bit poke,
                            output int n_pe, output int pe_cyc, output int ack_cyc, output int n_ack);
        cw_t e;
        bit  pe;
        n_pe = 0; pe_cyc = 0; ack_cyc = 0; n_ack = 0;
        e = exp_word(opc, zv);
        opcode = opc;
        z      = zv;
        sb_q.push_back(e);
        if (step) step_req = 1'b1; else run = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(pe);
            step_req = poke && (k <= 2);
            run      = 1'b0;
            if (step_ack === 1'b1) begin
                n_ack++;
                if (ack_cyc == 0) ack_cyc = k;
            end
            if (pe) begin
                n_pe++;
                pe_cyc = k;
                z = ~zv;
                #1;
                vectors++;
                if ({s_abs, s_inc} !== {e.s_abs, e.s_inc}) begin
                    miscompares++;
                    $display("FAIL exec_hold: got abs/inc=%b after z toggle, required %b", {s_abs, s_inc}, {e.s_abs, e.s_inc});
                end
            end
        end
        step_req = 1'b0;
    endtask

    task automatic test_reset();
        bit pe;
        reset = 1'b0; run = 1'b0; step_req = 1'b0; resume = 1'b0; z = 1'b0; opcode = I_NOP;
        tick(pe);
        tick(pe);
        vectors++;
        if ({busy, halted, step_ack, illegal, pc_en} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_status: got busy/halted/ack/ill/pc_en=%b, required 00000", {busy, halted, step_ack, illegal, pc_en});
        end
        vectors++;
        if (retired !== 16'd0 || b_retired !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_retired: got %0d/%0d, required 0/0", retired, b_retired);
        end
        vectors++;
        if ({op, s_inc, s_abs, s_inm} !== 6'b000100) begin
            miscompares++;
            $display("FAIL reset_defaults: got op/inc/abs/inm=%b, required 000100", {op, s_inc, s_abs, s_inm});
        end
        reset = 1'b1;
        tick(pe);
        tick(pe);
        tick(pe);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_without_run: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_run_seq();
        logic [31:0] w3, wz, pt;
        prog_q = '{I_LI, I_ALU2, I_NOP};
        run_prog(w3, wz, pt);
        vectors++;
        if (w3 !== 32'h14 || wz !== 32'h10 || pt !== 32'h54) begin
            miscompares++;
            $display("FAIL seq_timing: got we3=%h wez=%h pc_en=%h, required 14 10 54", w3, wz, pt);
        end
        vectors++;
        if (retired !== 16'd3 || busy !== 1'b0 || illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL seq_end: got retired=%0d busy=%b illegal=%b, required 3 0 0", retired, busy, illegal);
        end
    endtask

    task automatic test_jumps();
        logic [5:0] opcs [5] = '{I_JZ, I_JNZ, I_JZ, I_JNZ, I_J};
        logic       zs   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int n_pe, pe_cyc, ack_cyc, n_ack;
        for (int i = 0; i < 5; i++) begin
            exec_one(opcs[i], zs[i], 1'b0, 1'b0, n_pe, pe_cyc, ack_cyc, n_ack);
            vectors++;
            if (n_pe != 1 || pe_cyc != 2 || n_ack != 0) begin
                miscompares++;
                $display("FAIL jump_%0d: got pc_en=%0d at cycle %0d acks=%0d, required 1 at 2, 0", i, n_pe, pe_cyc, n_ack);
            end
        end
    endtask

    task automatic test_step();
        int n_pe, pe_cyc, ack_cyc, n_ack;
        exec_one(I_LI, 1'b0, 1'b1, 1'b0, n_pe, pe_cyc, ack_cyc, n_ack);
        vectors++;
        if (n_pe != 1 || ack_cyc != pe_cyc + 1 || n_ack != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL step_single: got pc_en=%0d ack_cyc=%0d (exec %0d) acks=%0d busy=%b, required 1 exec+1 1 0",
                     n_pe, ack_cyc, pe_cyc, n_ack, busy);
        end
        exec_one(I_ALU7, 1'b0, 1'b1, 1'b1, n_pe, pe_cyc, ack_cyc, n_ack);
        vectors++;
        if (n_pe != 1 || n_ack != 1 || retired !== 16'd10) begin
            miscompares++;
            $display("FAIL step_busy_drop: got pc_en=%0d acks=%0d retired=%0d, required 1 1 10", n_pe, n_ack, retired);
        end
    endtask

    task automatic test_halt();
        bit pe;
        int n_pe = 0;
        opcode = I_HALT;
        sb_q.push_back(exp_word(I_HALT, z));
        run = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(pe);
            if (pe) n_pe++;
            step_req = (k == 6);
        end
        vectors++;
        if (n_pe != 1 || halted !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_stop: got pc_en=%0d halted=%b busy=%b, required 1 1 0", n_pe, halted, busy);
        end
        opcode = I_NOP;
        sb_q.push_back(exp_word(I_NOP, z));
        resume = 1'b1;
        tick(pe);
        resume = 1'b0;
        vectors++;
        if (halted !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL resume_idle: got halted=%b busy=%b, required 0 0", halted, busy);
        end
        tick(pe);
        vectors++;
        if (busy !== 1'b1 || pe) begin
            miscompares++;
            $display("FAIL resume_fetch: got busy=%b pc_en=%b, required 1 0", busy, pe);
        end
        tick(pe);
        run = 1'b0;
        vectors++;
        if (!pe) begin
            miscompares++;
            $display("FAIL resume_exec: got pc_en=0, required 1");
        end
        tick(pe);
    endtask

    task automatic test_illegal();
        int n_pe, pe_cyc, ack_cyc, n_ack;
        exec_one(I_ILL, 1'b0, 1'b0, 1'b0, n_pe, pe_cyc, ack_cyc, n_ack);
        vectors++;
        if (n_pe != 1 || illegal !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_set: got pc_en=%0d illegal=%b, required 1 1", n_pe, illegal);
        end
        exec_one(I_NOP, 1'b0, 1'b0, 1'b0, n_pe, pe_cyc, ack_cyc, n_ack);
        exec_one(I_LI, 1'b0, 1'b0, 1'b0, n_pe, pe_cyc, ack_cyc, n_ack);
        vectors++;
        if (illegal !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_sticky: got illegal=%b, required 1", illegal);
        end
    endtask

    task automatic test_saturate();
        logic [31:0] w3, wz, pt;
        apply_reset();
        vectors++;
        if (illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_reset: got illegal=%b, required 0", illegal);
        end
        for (int i = 0; i < 14; i++) prog_q.push_back(I_NOP);
        run_prog(w3, wz, pt);
        vectors++;
        if (b_retired !== 4'd14 || retired !== 16'd14) begin
            miscompares++;
            $display("FAIL count_14: got %0d/%0d, required 14/14", b_retired, retired);
        end
        prog_q.push_back(I_NOP);
        run_prog(w3, wz, pt);
        vectors++;
        if (b_retired !== 4'd15) begin
            miscompares++;
            $display("FAIL count_15: got %0d, required 15", b_retired);
        end
        for (int i = 0; i < 5; i++) prog_q.push_back(I_NOP);
        run_prog(w3, wz, pt);
        vectors++;
        if (b_retired !== 4'd15 || retired !== 16'd20) begin
            miscompares++;
            $display("FAIL count_saturate: got %0d/%0d, required 15/20", b_retired, retired);
        end
    endtask

    task automatic test_reset_mid_exec();
        bit pe;
        bit seen = 1'b0;
        opcode = I_ALU3;
        sb_q.push_back(exp_word(I_ALU3, z));
        run = 1'b1;
        for (int k = 1; k <= 6 && !seen; k++) begin
            tick(pe);
            seen = pe;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL mid_exec_timeout: got no pc_en, required one");
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({we3, wez, pc_en, busy, halted, step_ack} !== 6'b0 || op !== 3'b000 || retired !== 16'd0) begin
            miscompares++;
            $display("FAIL async_reset: got en/status=%b op=%b retired=%0d, required 000000 000 0",
                     {we3, wez, pc_en, busy, halted, step_ack}, op, retired);
        end
        run = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick(pe);
        vectors++;
        if (sb_q.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL final_state: got pending=%0d busy=%b, required 0 0", sb_q.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_run_seq();
        test_jumps();
        test_step();
        test_halt();
        test_illegal();
        test_saturate();
        test_reset_mid_exec();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
